// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register master.
// No timing of its own; pure definitions.
// No flow control here.
package spi_reg_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  localparam int FRAME_LEN_RW = 24;
  localparam int FRAME_LEN_ST = 16;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_STATUS = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Frame is left-justified in 24 bits so the MSB is always bit 23;
  // a 16-bit STATUS frame simply never shifts out the low byte.
  function automatic logic [23:0] build_frame(input op_e op, input logic [7:0] addr,
                                              input logic [7:0] wdata);
    logic [23:0] f;
    case (op)
      OP_WRITE:  f = {CMD_WRITE, addr, wdata};
      OP_READ:   f = {CMD_READ, addr, 8'h00};
      OP_STATUS: f = {CMD_STATUS, 16'h0000};
      default:   f = 24'h000000;
    endcase
    return f;
  endfunction

  // Index of the last bit counted down from, i.e. frame length minus one.
  function automatic logic [4:0] frame_last_bit(input op_e op);
    return (op == OP_STATUS) ? 5'(FRAME_LEN_ST - 1) : 5'(FRAME_LEN_RW - 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one-cycle rise/fall strobes alternating every CLK_DIV cycles while enabled.
// First rise strobe CLK_DIV cycles after en goes high; strobes then every CLK_DIV cycles.
// No backpressure; dropping en resets the phase so the next frame starts with a rise.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase;
  logic       tick;

  assign tick = en && (cnt == 8'd0);
  assign rise = tick && !phase;
  assign fall = tick && phase;

  // Count down to zero, reload on every edge strobe, toggle which edge comes next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= DIV_LOAD;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= DIV_LOAD;
      phase <= 1'b0;
    end else if (cnt == 8'd0) begin
      cnt   <= DIV_LOAD;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing one register transaction (WRITE/READ/STATUS) per cs_n assertion.
// Response 1+2*N*CLK_DIV cycles after accept (N=24 or 16); reserved op responds next cycle.
// req_ready low from accept until CS_IDLE cycles after the frame ends; no queueing.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] GAP_LOAD = 8'(CS_IDLE - 1);

  state_e      state, state_n;
  op_e         op_q, op_n;
  logic [23:0] tx, tx_n;
  logic [7:0]  rx, rx_n;
  logic [4:0]  bit_cnt, bit_n;
  logic [7:0]  gap_cnt, gap_n;
  logic        sclk_n, cs_n_n, mosi_n, rsp_valid_n;
  logic [7:0]  rsp_rdata_n;
  logic        rise_d;
  logic        rise, fall;
  logic [23:0] frame;
  op_e         req_op_e;

  assign req_op_e  = op_e'(req_op);
  assign frame     = build_frame(req_op_e, req_addr, req_wdata);
  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == ST_SETUP) || (state == ST_SHIFT)),
    .rise  (rise),
    .fall  (fall)
  );

  // State and datapath registers; reset drives the pins idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_WRITE;
      tx        <= 24'h0;
      rx        <= 8'h00;
      bit_cnt   <= 5'd0;
      gap_cnt   <= 8'd0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rise_d    <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      tx        <= tx_n;
      rx        <= rx_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      sclk      <= sclk_n;
      cs_n      <= cs_n_n;
      mosi      <= mosi_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rise_d    <= rise;
    end
  end

  // Next-state and pin logic for the IDLE -> SETUP -> SHIFT -> GAP sequence.
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    tx_n        = tx;
    rx_n        = rx;
    bit_n       = bit_cnt;
    gap_n       = gap_cnt;
    sclk_n      = sclk;
    cs_n_n      = cs_n;
    mosi_n      = mosi;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;

    // rise_d marks the first cycle sclk is high; miso is taken there.
    if (rise_d) rx_n = {rx[6:0], miso};

    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          op_n = req_op_e;
          if (req_op_e == OP_RSVD) begin
            rsp_valid_n = 1'b1;
            rsp_rdata_n = 8'h00;
            gap_n       = 8'd0;
            state_n     = ST_GAP;
          end else begin
            cs_n_n  = 1'b0;
            mosi_n  = frame[23];
            tx_n    = {frame[22:0], 1'b0};
            bit_n   = frame_last_bit(req_op_e);
            state_n = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (rise) begin
          sclk_n = 1'b1;
        end else if (fall) begin
          sclk_n = 1'b0;
          if (bit_cnt == 5'd0) begin
            cs_n_n      = 1'b1;
            mosi_n      = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = (op_q == OP_WRITE) ? 8'h00 : rx;
            gap_n       = GAP_LOAD;
            state_n     = ST_GAP;
          end else begin
            bit_n  = bit_cnt - 5'd1;
            mosi_n = tx[23];
            tx_n   = {tx[22:0], 1'b0};
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_n = ST_IDLE;
        else                 gap_n   = gap_cnt - 8'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: per-cycle comparison against a timing-formula model,
// directed transactions with hand-computed cycle numbers and data,
// and a simple mode-0 slave that shifts a response onto miso on sclk falls.
module tb_spi_reg_master;

  localparam int D   = 4;
  localparam int CSI = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       miso = 1'b0;
  logic       req_ready, rsp_valid, busy, sclk, cs_n, mosi;
  logic [7:0] rsp_rdata;

  spi_reg_master #(.CLK_DIV(D), .CS_IDLE(CSI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- slave: shifts resp_lj MSB first, advancing on each sclk fall
  logic [23:0] resp_lj = 24'h0;
  logic [7:0]  slave_byte = 8'h00;
  int          falls = 0;
  logic        sclk_prev = 1'b0;

  always @(posedge clk) begin
    #2;
    if (cs_n) begin
      falls = 0;
      miso  = 1'b0;
    end else begin
      if (sclk_prev && !sclk) falls++;
      miso = (falls < 24) ? resp_lj[23 - falls] : 1'b0;
    end
    sclk_prev = sclk;
  end

  // ---------------- mosi seen at each sclk rise
  logic [23:0] cap = 24'h0;
  int          rises = 0;
  always @(posedge sclk) begin
    cap = {cap[22:0], mosi};
    rises++;
  end

  // ---------------- reference model: outputs as a function of cycles since accept
  bit          m_have = 1'b0;
  int          m_acc = 0;
  int          m_T = 0;
  int          m_Trdy = 0;
  logic [23:0] m_frame = 24'h0;
  logic [7:0]  m_rd = 8'h00;
  logic [7:0]  m_hold = 8'h00;

  always @(negedge clk) begin
    int   t;
    int   n;
    logic e_ready, e_sclk, e_cs_n, e_mosi, e_vld;
    if (!rst_n) begin
      m_have = 1'b0;
      m_hold = 8'h00;
    end
    e_ready = 1'b1; e_sclk = 1'b0; e_cs_n = 1'b1; e_mosi = 1'b0; e_vld = 1'b0;
    if (m_have) begin
      t = cyc - m_acc;
      if (t < m_Trdy) e_ready = 1'b0;
      if (t >= 1 && t < m_T) begin
        e_cs_n = 1'b0;
        e_sclk = (((t - 1) / D) % 2) == 1;
        e_mosi = m_frame[23 - ((t - 1) / (2 * D))];
      end
      if (t == m_T) begin
        e_vld  = 1'b1;
        m_hold = m_rd;
      end
    end
    chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    chk("busy",      {31'd0, busy},      {31'd0, ~e_ready});
    chk("sclk",      {31'd0, sclk},      {31'd0, e_sclk});
    chk("cs_n",      {31'd0, cs_n},      {31'd0, e_cs_n});
    chk("mosi",      {31'd0, mosi},      {31'd0, e_mosi});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_vld});
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_hold});
    if (rst_n && e_ready && req_valid) begin
      m_have = 1'b1;
      m_acc  = cyc;
      case (req_op)
        2'd0:    m_frame = {8'h02, req_addr, req_wdata};
        2'd1:    m_frame = {8'h03, req_addr, 8'h00};
        2'd2:    m_frame = {8'h05, 16'h0000};
        default: m_frame = 24'h0;
      endcase
      n      = (req_op == 2'd2) ? 16 : 24;
      m_T    = (req_op == 2'd3) ? 1 : 1 + 2 * n * D;
      m_Trdy = (req_op == 2'd3) ? 2 : m_T + CSI;
      m_rd   = (req_op == 2'd1 || req_op == 2'd2) ? slave_byte : 8'h00;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1)
  task automatic wait_ready(output int acc);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("accept_timeout", 0, 1);
    acc = cyc;
  endtask

  task automatic wait_rsp(input bit pulse, output int c);
    int n = 0;
    while (!rsp_valid && n < 2000) begin
      req_valid = pulse && (n >= 60) && (n < 63);
      req_op    = 2'd3;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    if (n >= 2000) chk("rsp_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("ready_timeout", 0, 1);
    c = cyc;
  endtask

  int last_rises = 0;

  task automatic do_txn(input string nm, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] w, input logic [7:0] sb, input bit pulse,
                        input int exp_t, input int exp_rdy, input logic [7:0] exp_rd);
    int acc, tr, tq, r0;
    slave_byte = sb;
    resp_lj    = (op == 2'd2) ? {8'h96, sb, 8'h00} : {8'h5A, 8'hC3, sb};
    r0         = rises;
    req_op = op; req_addr = a; req_wdata = w; req_valid = 1'b1;
    wait_ready(acc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    wait_rsp(pulse, tr);
    chk({nm, "_rsp_cycle"}, tr - acc, exp_t);
    chk({nm, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rd});
    wait_idle(tq);
    chk({nm, "_ready_cycle"}, tq - acc, exp_rdy);
    last_rises = rises - r0;
  endtask

  // ---------------- directed sequence
  initial begin
    int acc1, acc2, tcs, tr, tq, cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata",     {24'd0, rsp_rdata}, 32'h00);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_sclk",      {31'd0, sclk},      32'd0);
    chk("rst_cs_n",      {31'd0, cs_n},      32'd1);
    chk("rst_mosi",      {31'd0, mosi},      32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // WRITE 0x10 <- 0xA5
    do_txn("write", 2'd0, 8'h10, 8'hA5, 8'h77, 1'b0, 193, 197, 8'h00);
    chk("write_mosi_frame", {8'd0, cap}, 32'h0210A5);
    chk("write_rises", last_rises, 24);

    // READ 0x10, slave returns 0xA5 in the final byte
    do_txn("read", 2'd1, 8'h10, 8'h00, 8'hA5, 1'b0, 193, 197, 8'hA5);
    chk("read_mosi_cmd_addr", {16'd0, cap[23:8]}, 32'h0310);
    chk("read_rises", last_rises, 24);

    // STATUS, slave returns 0x3C
    do_txn("status", 2'd2, 8'hFF, 8'hFF, 8'h3C, 1'b0, 129, 133, 8'h3C);
    chk("status_rises", last_rises, 16);
    chk("status_mosi", {16'd0, cap[15:0]}, 32'h0500);

    // Back-to-back WRITEs with req_valid held high
    req_op = 2'd0; req_addr = 8'h21; req_wdata = 8'h5A; req_valid = 1'b1;
    wait_ready(acc1);
    @(posedge clk); #1;
    req_addr = 8'h22; req_wdata = 8'hC3;
    cnt = 0;
    while (!cs_n && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 2000) chk("b2b_cs_timeout", 0, 1);
    tcs = cyc;
    chk("b2b_first_end", tcs - acc1, 193);
    wait_ready(acc2);
    chk("b2b_second_accept", acc2 - acc1, 197);
    chk("b2b_cs_high_gap", acc2 - tcs, CSI);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(1'b0, tr);
    chk("b2b_second_rsp", tr - acc2, 193);
    chk("b2b_second_frame", {8'd0, cap}, 32'h0222C3);
    wait_idle(tq);

    // Reset asserted in cycle 50 of a READ
    slave_byte = 8'h81;
    resp_lj    = {8'h5A, 8'hC3, 8'h81};
    req_op = 2'd1; req_addr = 8'h10; req_valid = 1'b1;
    wait_ready(acc1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt = 0;
    while (cyc < acc1 + 50 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    chk("abort_pre_cs_n", {31'd0, cs_n}, 32'd0);
    chk("abort_pre_mosi", {31'd0, mosi}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_mosi", {31'd0, mosi}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 0);
    do_txn("read_after_rst", 2'd1, 8'h44, 8'h00, 8'h5E, 1'b0, 193, 197, 8'h5E);

    // Reserved op: no pin activity, immediate zero response
    do_txn("rsvd", 2'd3, 8'hAA, 8'h55, 8'hEE, 1'b0, 1, 2, 8'h00);
    chk("rsvd_rises", last_rises, 0);

    // WRITE with reserved-op pulses on req_valid while busy
    do_txn("write_pulsed", 2'd0, 8'h33, 8'h99, 8'h12, 1'b1, 193, 197, 8'h00);
    chk("write_pulsed_frame", {8'd0, cap}, 32'h023399);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI mode-0 master that issues single register transactions to the FPGA SPI register slave.
- Sits between the on-chip controller logic (request/response handshake) and the SPI pins (sclk, cs_n, mosi, miso).
- Serialises command, address and data bytes MSB first, and captures the returned read or status byte.
- One transaction per cs_n assertion; no bursts.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 4..255 (the slave needs at least 4 for its 2-flop edge sync).
- CS_IDLE, 4, clk cycles cs_n stays high after a transaction before the next request is accepted; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_op  in  2  0=WRITE, 1=READ, 2=STATUS, 3=reserved
- req_addr  in  8  register address (WRITE/READ)
- req_wdata  in  8  write data (WRITE)
- rsp_valid  out  1  one-cycle pulse when the transaction completes
- rsp_rdata  out  8  captured byte; held until the next rsp_valid
- busy  out  1  high from request accept until req_ready returns
- sclk  out  1  SPI clock, idle low
- cs_n  out  1  chip select, active low
- mosi  out  1  master data out
- miso  in  1  slave data in

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0x00, busy=0, sclk=0, cs_n=1, mosi=0.
- Reset is asynchronous and may occur mid-transaction: pins go idle at once, and no rsp_valid is issued for the aborted transaction.
- Accept: req_valid && req_ready in cycle 0. The master latches op/addr/wdata and drops req_ready. Inputs are don't-care afterwards.
- Frames, all MSB first:
  - WRITE: 0x02, addr, wdata (24 bits).
  - READ: 0x03, addr, 0x00 dummy (24 bits).
  - STATUS: 0x05, 0x00 dummy (16 bits).
- States: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- SETUP (cycle 1): cs_n=0, mosi=frame bit N-1.
- SHIFT timing, for bit k=0..N-1 (counted from MSB):
  - sclk rises at cycle 1+CLK_DIV*(2k+1); miso is sampled in that same cycle.
  - sclk falls at cycle 1+CLK_DIV*(2k+2); mosi advances to the next bit on that fall.
- Last fall, cycle T=1+2N*CLK_DIV:
  - cs_n=1, sclk=0, mosi=0, rsp_valid=1 for one cycle.
  - rsp_rdata updated in the same cycle.
  - Enter GAP.
- Capture: READ and STATUS load rsp_rdata with the 8 miso bits sampled during the final byte. WRITE loads rsp_rdata=0x00.
- GAP: CS_IDLE cycles with cs_n=1, then req_ready=1 and busy=0 at cycle T+CS_IDLE.
- Reserved op=3: accepted, no pin activity, rsp_valid at cycle 1 with rsp_rdata=0x00, req_ready back at cycle 2.
- req_valid while busy is ignored; there is no queueing.
- Bit counter is 5 bits, counts down to 0. Divider counter is 8 bits, reloads to CLK_DIV-1 at each edge.
- sclk never glitches: exactly N rising edges per frame, and sclk is low whenever cs_n changes.

Decomposition:
- Shared package spi_reg_pkg holds:
  - opcode constants CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_STATUS=8'h05;
  - op encodings OP_WRITE/OP_READ/OP_STATUS/OP_RSVD;
  - frame lengths 24/16.
- Sub-module spi_clk_gen: divider producing one-cycle rise/fall strobes while enabled. The parent FSM owns sclk, cs_n, mosi and the shift registers.

Test Plan:
- CLK_DIV=4, WRITE addr=0x10 wdata=0xA5, accepted cycle 0:
  - mosi shows 0x02,0x10,0xA5 at 24 rising edges;
  - cs_n high and rsp_valid at cycle 193;
  - rsp_rdata=0x00; req_ready at cycle 197.
- READ addr=0x10 against a slave model returning 0xA5 in byte 3 -> rsp_rdata=0xA5 at cycle 193; first two bytes on mosi are 0x03,0x10.
- STATUS with slave returning 0x3C -> 16 sclk rises, rsp_valid at cycle 129, rsp_rdata=0x3C.
- Back-to-back: req_valid held high for two WRITEs -> second accept only at cycle 197; cs_n high for exactly 4 cycles between frames.
- rst_n asserted at cycle 50 of a READ -> cs_n=1, sclk=0, mosi=0 immediately; no rsp_valid; after release, req_ready=1 and a new READ completes normally.
- op=3 -> no sclk edges, cs_n stays 1, rsp_valid at cycle 1 with 0x00; req_valid pulses during busy are ignored.
